// File: rtl/reg_dump_unit_pkg.sv
// -----------------------------------------------------------------------------
// reg_dump_unit_pkg
// Shared definitions for the debug dump path.
//   state_t          - dump FSM state encoding (2 bits)
//   byte_order_t     - byte order used on the debug byte stream
//   DBG_BYTE_ORDER   - debug-protocol byte order, also used by the memory dump
//   bytes_per_word() - number of output bytes carried by one register word
// -----------------------------------------------------------------------------
package reg_dump_unit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    typedef enum logic {
        BO_LITTLE = 1'b0,
        BO_BIG    = 1'b1
    } byte_order_t;

    // Least significant byte of every word goes out first.
    localparam byte_order_t DBG_BYTE_ORDER = BO_LITTLE;

    function automatic int bytes_per_word(input int nb_register, input int nb_byte);
        return nb_register / nb_byte;
    endfunction

endpackage

// File: rtl/reg_dump_unit.sv
// -----------------------------------------------------------------------------
// reg_dump_unit
// Reads every register of the CPU register bank through one read port and
// streams the contents out as bytes over a valid/ready handshake.
//
// Ports:
//   i_clk       clock, rising edge
//   i_reset     synchronous active-high reset (aborts a dump in progress)
//   i_start     dump request, sampled only while idle
//   o_r_addr    read address to the register bank
//   i_r_data    combinational read data for o_r_addr
//   o_tx_data   output byte
//   o_tx_valid  o_tx_data holds a valid byte
//   i_tx_ready  sink accepts the byte this cycle
//   o_busy      high from leaving IDLE until back in IDLE
//   o_done      one-cycle pulse after the last byte is accepted
// -----------------------------------------------------------------------------
module reg_dump_unit
    import reg_dump_unit_pkg::*;
#(
    parameter int NB_REGISTER = 32,
    parameter int NB_ADDR     = 5,
    parameter int NB_BYTE     = 8
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_start,
    output logic [NB_ADDR-1:0]     o_r_addr,
    input  logic [NB_REGISTER-1:0] i_r_data,
    output logic [NB_BYTE-1:0]     o_tx_data,
    output logic                   o_tx_valid,
    input  logic                   i_tx_ready,
    output logic                   o_busy,
    output logic                   o_done
);

    localparam int BPW     = bytes_per_word(NB_REGISTER, NB_BYTE);
    localparam int NB_BIDX = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [NB_BIDX-1:0] LAST_BYTE = NB_BIDX'(BPW - 1);
    // Last register found by comparison so the index never relies on wrapping.
    localparam logic [NB_ADDR-1:0] LAST_REG  = '1;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [NB_ADDR-1:0]     r_reg_idx;
    logic [NB_ADDR-1:0]     w_reg_idx_next;
    logic [NB_BIDX-1:0]     r_byte_idx;
    logic [NB_BIDX-1:0]     w_byte_idx_next;
    logic [NB_REGISTER-1:0] r_word;
    logic [NB_REGISTER-1:0] w_word_next;

    logic [NB_BIDX-1:0]     w_sel;
    int                     w_lsb;
    logic [NB_BYTE-1:0]     w_byte;

    // Byte lane selection: stream position mapped to a lane of the buffer.
    always_comb begin
        w_sel  = (DBG_BYTE_ORDER == BO_LITTLE) ? r_byte_idx : (LAST_BYTE - r_byte_idx);
        w_lsb  = int'(w_sel) * NB_BYTE;
        w_byte = r_word[w_lsb +: NB_BYTE];
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_reg_idx  <= '0;
            r_byte_idx <= '0;
            r_word     <= '0;
        end else begin
            r_state    <= w_state_next;
            r_reg_idx  <= w_reg_idx_next;
            r_byte_idx <= w_byte_idx_next;
            r_word     <= w_word_next;
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_reg_idx_next  = r_reg_idx;
        w_byte_idx_next = r_byte_idx;
        w_word_next     = r_word;
        o_r_addr        = '0;
        o_tx_data       = '0;
        o_tx_valid      = 1'b0;
        o_busy          = 1'b0;
        o_done          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next   = ST_LOAD;
                    w_reg_idx_next = '0;
                end
            end

            ST_LOAD: begin
                o_busy          = 1'b1;
                o_r_addr        = r_reg_idx;
                w_word_next     = i_r_data;
                w_byte_idx_next = '0;
                w_state_next    = ST_SEND;
            end

            ST_SEND: begin
                o_busy     = 1'b1;
                o_tx_valid = 1'b1;
                o_tx_data  = w_byte;
                if (i_tx_ready) begin
                    if (r_byte_idx != LAST_BYTE) begin
                        w_byte_idx_next = r_byte_idx + 1'b1;
                    end else if (r_reg_idx != LAST_REG) begin
                        w_reg_idx_next = r_reg_idx + 1'b1;
                        w_state_next   = ST_LOAD;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                o_busy       = 1'b1;
                o_done       = 1'b1;
                w_state_next = ST_IDLE;
            end

            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_reg_dump_unit.sv
// -----------------------------------------------------------------------------
// tb_reg_dump_unit
// Scoreboard bench: expected bytes are queued when a dump is requested and a
// monitor pops and compares on every accepted byte.
// -----------------------------------------------------------------------------
module tb_reg_dump_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        ready;
    logic [4:0]  r_addr;
    logic [31:0] r_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        done;

    logic [31:0] bank  [32];
    logic [31:0] exp_w [32];
    logic [7:0]  exp_q [$];
    logic [7:0]  mon_e;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_acc  = 0;
    int n_done = 0;

    always #5 clk = ~clk;

    assign r_data = bank[r_addr];

    reg_dump_unit #(
        .NB_REGISTER(32),
        .NB_ADDR    (5),
        .NB_BYTE    (8)
    ) dut (
        .i_clk     (clk),
        .i_reset   (rst),
        .i_start   (start),
        .o_r_addr  (r_addr),
        .i_r_data  (r_data),
        .o_tx_data (tx_data),
        .o_tx_valid(tx_valid),
        .i_tx_ready(ready),
        .o_busy    (busy),
        .o_done    (done)
    );

    // Monitor: every handshake consumes one expected byte.
    always @(negedge clk) begin
        if (done) n_done++;
        if (tx_valid && ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL byte%0d: got %02h, no byte expected", n_acc, tx_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (tx_data !== mon_e) begin
                    n_err++;
                    $display("FAIL byte%0d: got %02h expected %02h", n_acc, tx_data, mon_e);
                end
            end
            n_acc++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_dump();
        for (int r = 0; r < 32; r++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(exp_w[r][8*b +: 8]);
    endtask

    task automatic start_pulse();
        n_acc = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_acc(input int k);
        int t;
        t = 0;
        while (n_acc < k && t < 2000) begin
            @(posedge clk); #1;
            t++;
        end
        if (n_acc < k) begin
            n_err++;
            $display("FAIL wait_acc: got %0d bytes required %0d", n_acc, k);
        end
    endtask

    task automatic wait_done();
        int t;
        logic seen;
        t    = 0;
        seen = 1'b0;
        while (!seen && t < 600) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            t++;
        end
        chk("done_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic end_dump(input string name, input int d0);
        chk({name, "_bytes"}, n_acc, 32'd128);
        chk({name, "_qempty"}, exp_q.size(), 32'd0);
        chk({name, "_ndone"}, n_done, d0 + 1);
        chk({name, "_busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int d0;
        int cyc;
        rst   = 1'b1;
        start = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 32; i++) begin
            bank[i]  = 32'd0;
            exp_w[i] = 32'd0;
        end
        bank[1]   = 32'h11223344;
        bank[31]  = 32'hDEADBEEF;
        exp_w[1]  = 32'h11223344;
        exp_w[31] = 32'hDEADBEEF;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_addr",  {27'd0, r_addr}, 32'd0);
        chk("rst_data",  {24'd0, tx_data}, 32'd0);
        chk("rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_busy",  {31'd0, busy}, 32'd0);
        chk("rst_done",  {31'd0, done}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: plain dump, ready held high
        d0 = n_done;
        push_dump();
        start_pulse();
        wait_done();
        end_dump("t1", d0);

        // 2: backpressure inside reg1 (byte 5 = 0x33 stalls two cycles)
        d0 = n_done;
        push_dump();
        start_pulse();
        wait_acc(5);
        chk("t2_pre", {24'd0, tx_data}, 32'h33);
        ready = 1'b0;
        @(negedge clk);
        chk("t2_hold1_data",  {24'd0, tx_data}, 32'h33);
        chk("t2_hold1_valid", {31'd0, tx_valid}, 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t2_hold2_data",  {24'd0, tx_data}, 32'h33);
        chk("t2_hold2_valid", {31'd0, tx_valid}, 32'd1);
        @(posedge clk); #1;
        ready = 1'b1;
        wait_done();
        end_dump("t2", d0);

        // 3: start re-pulsed mid-dump is ignored
        d0 = n_done;
        push_dump();
        start_pulse();
        wait_acc(50);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done();
        end_dump("t3", d0);
        repeat (3) @(negedge clk);
        chk("t3_no_restart", {31'd0, busy}, 32'd0);
        chk("t3_ndone_stable", n_done, d0 + 1);
        @(posedge clk); #1;

        // 4: reset at byte 70 aborts, then restart from reg0 byte0
        d0 = n_done;
        push_dump();
        start_pulse();
        wait_acc(70);
        rst   = 1'b1;
        ready = 1'b0;
        @(posedge clk); #1;
        chk("t4_valid", {31'd0, tx_valid}, 32'd0);
        chk("t4_busy",  {31'd0, busy}, 32'd0);
        chk("t4_addr",  {27'd0, r_addr}, 32'd0);
        chk("t4_data",  {24'd0, tx_data}, 32'd0);
        rst   = 1'b0;
        ready = 1'b1;
        chk("t4_bytes_before_abort", n_acc, 32'd70);
        exp_q.delete();
        repeat (5) @(negedge clk);
        chk("t4_no_done",   n_done, d0);
        chk("t4_idle_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        push_dump();
        start_pulse();
        wait_done();
        end_dump("t4r", d0);

        // 5a: write reg5 while reg2 is being sent -> new value appears
        d0 = n_done;
        exp_w[5] = 32'hCAFEF00D;
        push_dump();
        start_pulse();
        wait_acc(9);
        bank[5] = 32'hCAFEF00D;
        wait_done();
        end_dump("t5a", d0);

        // 5b: write reg5 after its LOAD -> previous value dumped
        d0 = n_done;
        push_dump();
        start_pulse();
        wait_acc(21);
        bank[5] = 32'h12345678;
        wait_done();
        end_dump("t5b", d0);
        exp_w[5] = 32'h12345678;

        // 6: latency and total dump length
        d0 = n_done;
        push_dump();
        start_pulse();
        @(negedge clk);
        cyc = 1;
        chk("t6_load_addr",  {27'd0, r_addr}, 32'd0);
        chk("t6_load_busy",  {31'd0, busy}, 32'd1);
        chk("t6_load_valid", {31'd0, tx_valid}, 32'd0);
        @(negedge clk);
        cyc = 2;
        chk("t6_first_valid", {31'd0, tx_valid}, 32'd1);
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        chk("t6_done_cycle", cyc, 32'd161);
        @(negedge clk);
        chk("t6_busy_fall", {31'd0, busy}, 32'd0);
        chk("t6_done_once", {31'd0, done}, 32'd0);
        chk("t6_qempty", exp_q.size(), 32'd0);
        chk("t6_ndone", n_done, d0 + 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/reg_dump_unit.md
Name: reg_dump_unit

Overview:
Debug-path block that reads the CPU register bank through one of its read ports and streams the full contents out as bytes over a valid/ready handshake. Its usual sink is the debug UART transmitter.
- Sits directly downstream of the register bank. It drives the bank's read address and consumes the combinational read data.
- A dump is triggered by the debug controller via i_start.
- Emits 2**NB_ADDR words × (NB_REGISTER/NB_BYTE) bytes per dump.

Parameters:
- NB_REGISTER, 32, width of one register word; must be a multiple of NB_BYTE.
- NB_ADDR, 5, register address width; 2**NB_ADDR registers are dumped.
- NB_BYTE, 8, width of one output byte.

Ports:
- i_clk  in  1  clock; all state updates on the rising edge.
- i_reset  in  1  reset, synchronous, active-high.
- i_start  in  1  dump request; sampled only in IDLE.
- o_r_addr  out  NB_ADDR  read address to the register bank read port.
- i_r_data  in  NB_REGISTER  combinational read data from the bank for o_r_addr.
- o_tx_data  out  NB_BYTE  byte to the transmitter.
- o_tx_valid  out  1  o_tx_data holds a valid byte.
- i_tx_ready  in  1  transmitter accepts the byte this cycle.
- o_busy  out  1  high from leaving IDLE until return to IDLE.
- o_done  out  1  one-cycle pulse after the last byte is accepted.

Behaviour:
- Reset (synchronous, active-high):
  - State = IDLE; register index = 0; byte index = 0; word buffer = 0.
  - Outputs: o_r_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0.
  - A reset asserted mid-dump aborts it. Outputs take reset values after that edge and no further bytes are emitted. No o_done for the aborted dump.
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE:
  - o_busy=0, o_tx_valid=0, o_r_addr=0.
  - i_start=1 → LOAD with reg index=0.
- LOAD (exactly one cycle):
  - o_r_addr = reg index.
  - At the edge, latch i_r_data into the word buffer, set byte index=0, go to SEND.
- SEND:
  - o_tx_valid=1; o_tx_data = buffer[byte index*NB_BYTE +: NB_BYTE].
  - Byte order is little-endian: bits [7:0] first.
  - On valid&&ready, one of:
    - byte index < last: byte index+1, stay in SEND.
    - byte index = last and reg index < 2**NB_ADDR-1: reg index+1, go to LOAD.
    - byte index = last and reg index = max: go to DONE.
  - While valid && !ready: o_tx_data and o_tx_valid hold stable; no state change.
- DONE (one cycle):
  - o_done=1, o_busy=1, o_tx_valid=0, then IDLE.
- Latency:
  - i_start high at edge N → LOAD during cycle N+1 → first byte valid in cycle N+2.
  - With i_tx_ready held at 1: one byte per cycle, plus one LOAD bubble per register.
  - Full dump at defaults: 128 SEND cycles + 32 LOAD cycles + 1 DONE cycle.
- i_start while busy is ignored; it is not queued.
- i_start held high continuously: a new dump starts on the cycle after DONE, i.e. the first IDLE cycle.
- Register snapshot is per-word, taken at the LOAD edge. Bank writes on other registers during a dump are visible if they land before that register's LOAD. There is no whole-bank atomicity.
- Register 0 is dumped like any other register and reads 0 from the bank.
- Counter widths:
  - reg index: NB_ADDR bits. The last register is detected by comparison, not by wrap-around.
  - byte index: clog2(NB_REGISTER/NB_BYTE) bits, minimum 1.

Decomposition:
- Shared header holds:
  - FSM state encodings (2-bit: IDLE=0, LOAD=1, SEND=2, DONE=3).
  - BYTES_PER_WORD = NB_REGISTER/NB_BYTE.
  - The debug-protocol byte-order constant, also used by the memory-dump unit.
- No sub-module is required. The byte-select mux stays inline.

Test Plan:
1. Reset bank, preload reg1=0x11223344, reg31=0xDEADBEEF, others 0; pulse i_start; ready=1 → 128 bytes; bytes 4..7 = 44,33,22,11; bytes 124..127 = EF,BE,AD,DE; o_done pulses once right after byte 127; o_busy falls the cycle after.
2. Backpressure: ready toggles 1,0,0,1 pattern during reg1 → o_tx_data holds 0x33 stable across both ready=0 cycles; no byte is lost or duplicated.
3. i_start re-pulsed at byte 50 of a dump → ignored; exactly 128 bytes total and one o_done.
4. i_reset asserted at byte 70 → next cycle o_tx_valid=0, o_busy=0, o_r_addr=0; no o_done; a subsequent i_start restarts from reg0 byte0.
5. Bank write of reg5=0xCAFEF00D issued while the FSM is sending reg2 → dump shows 0D,F0,FE,CA at bytes 20..23. Same write issued after reg5's LOAD → old value is dumped.
6. Timing: i_start at edge N → o_r_addr=0 during N+1, first o_tx_valid in N+2; with ready=1 the dump completes 161 cycles after LOAD entry.
